idx_onehot_seq: RTL and testbench
=================================

IDX_ONEHOT_SEQ -- requirements
Module: idx_onehot_seq

Interface
REQ-001 Parameter DEPTH, default 2: command FIFO depth in entries, power of two, at least 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  command offered.
REQ-005 in_ready  output  1  command accepted this cycle when in_valid is also high.
REQ-006 in_idx  input  4  start index of the command.
REQ-007 in_len  input  4  beat count minus one; 0 means 1 beat, 15 means 16 beats.
REQ-008 out_valid  output  1  beat present on the out_* outputs.
REQ-009 out_ready  input  1  downstream accepts the beat.
REQ-010 out_onehot  output  16  one-hot decode of out_idx; bit out_idx is 1, all others 0.
REQ-011 out_idx  output  4  binary index of the current beat.
REQ-012 out_last  output  1  final beat of the current command.
REQ-013 busy  output  1  high when the FIFO is non-empty or a command is in progress.

Function
REQ-014 A command is accepted on a rising edge with in_valid=1 and in_ready=1, and is pushed into the FIFO.
REQ-015 in_ready shall equal !fifo_full, registered-state only, with no combinational path from out_ready.
REQ-016 When full, no push occurs even if a pop happens in the same cycle.
REQ-017 The sequencer has two states: IDLE and RUN.
REQ-018 In IDLE with the FIFO non-empty, the sequencer pops the head entry, loads cur_idx=idx and remaining=len, and enters RUN; out_valid rises the next cycle.
REQ-019 Minimum latency is 2 cycles: accept at edge N, out_valid=1 after edge N+1.
REQ-020 In RUN, out_valid=1, out_idx=cur_idx, out_onehot=1<<cur_idx, and out_last=(remaining==0).
REQ-021 A beat handshake occurs when out_valid=1 and out_ready=1.
REQ-022 On a non-last beat handshake, cur_idx increments modulo 16 (15 wraps to 0) and remaining decrements.
REQ-023 On a last beat handshake with the FIFO non-empty, the next command is popped and loaded in the same cycle, with no idle bubble between commands.
REQ-024 On a last beat handshake with the FIFO empty, the sequencer returns to IDLE and out_valid drops.
REQ-025 While out_valid=1 and out_ready=0, out_idx, out_onehot and out_last remain stable, and out_valid does not drop.
REQ-026 A simultaneous push and pop on a non-full FIFO is legal; the occupancy stays unchanged.
REQ-027 In IDLE, out_onehot is 16'h0000 and out_idx and out_last are 0.
REQ-028 out_onehot shall never have more than one bit set.
REQ-029 Commands are emitted strictly in acceptance order.

Reset
REQ-030 With rst=1 at a rising edge: FIFO emptied, state=IDLE, cur_idx=0, remaining=0.
REQ-031 Post-reset outputs: out_valid=0, out_onehot=0, out_idx=0, out_last=0, busy=0, in_ready=1.
REQ-032 A reset asserted mid-command discards the in-progress command and all queued commands, with no further beats emitted.
REQ-033 Inputs are ignored in the reset cycle.

Structure
REQ-034 The shared package holds the state encoding (IDLE=1'b0, RUN=1'b1), IDX_W=4, ONEHOT_W=16 and the command struct {idx, len}.
REQ-035 Sub-module sync_fifo instantiated once: width 8, depth DEPTH, with push/pop/full/empty and synchronous active-high reset.
REQ-036 The one-hot decode is a combinational function of the registered cur_idx, gated by state==RUN.

Verification
REQ-037 Single beat: command idx=3, len=0, out_ready=1 -> one beat, out_onehot=16'h0008, out_idx=3, out_last=1, appearing 2 cycles after acceptance; busy then drops.
REQ-038 Wrap: command idx=14, len=3, out_ready=1 -> out_idx sequence 14,15,0,1; out_onehot sequence 4000,8000,0001,0002; out_last only on the 4th beat.
REQ-039 Back-pressure: command idx=5, len=1, with out_ready held 0 for 5 cycles -> out_onehot=16'h0020 stable for 5 cycles; then out_ready=1 -> 0020 then 0040, with no drops or duplicates.
REQ-040 Back-to-back: commands (2,1) and (9,0) queued -> beats 2,3,9 on consecutive cycles with no bubble; out_last high on beats 3 and 9.
REQ-041 Full: DEPTH=2 with out_ready=0 and 4 commands offered -> in_ready=0 once the FIFO holds 2 entries behind the active command; no command is lost after out_ready is released; order preserved.
REQ-042 Mid-run reset: command idx=0, len=15, with rst pulsed at beat 6 -> out_valid=0 and busy=0 the next cycle, and no further beats until a new command.

Source files
------------

// File: rtl/idx_onehot_seq_pkg.sv
// Shared types and constants for the index-to-one-hot beat sequencer.
package idx_onehot_seq_pkg;

    localparam int IDX_W    = 4;
    localparam int ONEHOT_W = 16;
    localparam int CMD_W    = 2 * IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] len;
    } cmd_t;

    function automatic logic [ONEHOT_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] i);
        idx_to_onehot = ONEHOT_W'(1) << i;
    endfunction

endpackage

// File: rtl/idx_onehot_seq_fifo.sv
// Synchronous FIFO with extra-bit pointers; push is dropped when full, pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/idx_onehot_seq.sv
// Queues {idx, len} commands and emits len+1 consecutive one-hot beats per command.
//   state | meaning
//   IDLE  | no active command; pops the FIFO head when one is queued
//   RUN   | beat cur_idx presented; advances on out_ready, chains next command on last beat
module idx_onehot_seq
    import idx_onehot_seq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IDX_W-1:0]    in_idx,
    input  logic [IDX_W-1:0]    in_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ONEHOT_W-1:0] out_onehot,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_last,
    output logic                busy
);

    seq_state_t       state, state_nxt;
    logic [IDX_W-1:0] cur_idx, cur_idx_nxt;
    logic [IDX_W-1:0] remaining, remaining_nxt;
    cmd_t             in_cmd;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign in_cmd   = {in_idx, in_len};
    assign in_ready = !fifo_full;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .din   (in_cmd),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_idx   <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            cur_idx   <= cur_idx_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_idx_nxt   = cur_idx;
        remaining_nxt = remaining;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    cur_idx_nxt   = head.idx;
                    remaining_nxt = head.len;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (remaining != '0) begin
                        cur_idx_nxt   = cur_idx + IDX_W'(1);
                        remaining_nxt = remaining - IDX_W'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next command without an idle cycle.
                        pop           = 1'b1;
                        cur_idx_nxt   = head.idx;
                        remaining_nxt = head.len;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid  = (state == RUN);
    assign out_idx    = (state == RUN) ? cur_idx : '0;
    assign out_onehot = (state == RUN) ? idx_to_onehot(cur_idx) : '0;
    assign out_last   = (state == RUN) && (remaining == '0);
    assign busy       = !fifo_empty || (state == RUN);

endmodule

// File: tb/tb_idx_onehot_seq.sv
// Directed bench for idx_onehot_seq: reset, single beat, wrap, back-pressure, chaining, full FIFO, mid-run reset.
module tb_idx_onehot_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_idx;
    logic [3:0]  in_len;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_onehot;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] oh;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t beats[$];
    beat_t exp_q[$];

    idx_onehot_seq #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_len     (in_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are recorded half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            beats.push_back('{idx: out_idx, oh: out_onehot, last: out_last, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] i, input logic [3:0] l);
        in_valid = 1'b1;
        in_idx   = i;
        in_len   = l;
        for (int k = 0; k < 50 && !in_ready; k++) step();
        chk("push_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && busy; k++) step();
        chk("drain_busy", busy, 0);
    endtask

    task automatic exp_beat(input logic [3:0] i, input logic [15:0] oh, input logic l);
        exp_q.push_back('{idx: i, oh: oh, last: l, cyc: 0});
    endtask

    task automatic check_beats(input string name, input bit consec);
        chk($sformatf("%s_count", name), beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
            chk($sformatf("%s_idx%0d", name, i), beats[i].idx, exp_q[i].idx);
            chk($sformatf("%s_oh%0d", name, i), beats[i].oh, exp_q[i].oh);
            chk($sformatf("%s_last%0d", name, i), beats[i].last, exp_q[i].last);
            if (consec && i > 0)
                chk($sformatf("%s_gap%0d", name, i), beats[i].cyc - beats[i-1].cyc, 1);
        end
        beats.delete();
        exp_q.delete();
    endtask

    initial begin
        int n_pre;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_idx    = 4'd7;
        in_len    = 4'd2;
        out_ready = 1'b1;
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_onehot", out_onehot, 16'h0000);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        chk("rst_ignored_busy", busy, 0);
        beats.delete();

        // Single beat with two-cycle latency
        out_ready = 1'b1;
        push_cmd(4'd3, 4'd0);
        chk("single_lat_valid", out_valid, 0);
        step();
        chk("single_valid", out_valid, 1);
        chk("single_onehot", out_onehot, 16'h0008);
        chk("single_idx", out_idx, 3);
        chk("single_last", out_last, 1);
        step();
        chk("single_drop_valid", out_valid, 0);
        chk("single_drop_busy", busy, 0);
        chk("idle_onehot", out_onehot, 16'h0000);
        exp_beat(4'd3, 16'h0008, 1'b1);
        check_beats("single", 1'b1);

        // Index wrap 15 -> 0
        push_cmd(4'd14, 4'd3);
        drain();
        exp_beat(4'd14, 16'h4000, 1'b0);
        exp_beat(4'd15, 16'h8000, 1'b0);
        exp_beat(4'd0,  16'h0001, 1'b0);
        exp_beat(4'd1,  16'h0002, 1'b1);
        check_beats("wrap", 1'b1);

        // Back-pressure holds the beat stable
        out_ready = 1'b0;
        push_cmd(4'd5, 4'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid%0d", i), out_valid, 1);
            chk($sformatf("bp_onehot%0d", i), out_onehot, 16'h0020);
            chk($sformatf("bp_last%0d", i), out_last, 0);
            step();
        end
        out_ready = 1'b1;
        drain();
        exp_beat(4'd5, 16'h0020, 1'b0);
        exp_beat(4'd6, 16'h0040, 1'b1);
        check_beats("bp", 1'b1);

        // Back-to-back commands with no bubble
        out_ready = 1'b0;
        push_cmd(4'd2, 4'd1);
        push_cmd(4'd9, 4'd0);
        out_ready = 1'b1;
        drain();
        exp_beat(4'd2, 16'h0004, 1'b0);
        exp_beat(4'd3, 16'h0008, 1'b1);
        exp_beat(4'd9, 16'h0200, 1'b1);
        check_beats("b2b", 1'b1);

        // Full FIFO: one active plus two queued
        out_ready = 1'b0;
        push_cmd(4'd1, 4'd0);
        push_cmd(4'd4, 4'd0);
        push_cmd(4'd7, 4'd0);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_idx   = 4'd11;
        in_len   = 4'd0;
        step();
        chk("full_in_ready_hold", in_ready, 0);
        chk("full_active_idx", out_idx, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && !in_ready; k++) step();
        chk("full_release", in_ready, 1);
        step();
        in_valid = 1'b0;
        drain();
        exp_beat(4'd1,  16'h0002, 1'b1);
        exp_beat(4'd4,  16'h0010, 1'b1);
        exp_beat(4'd7,  16'h0080, 1'b1);
        exp_beat(4'd11, 16'h0800, 1'b1);
        check_beats("full", 1'b0);

        // Reset in the middle of a 16-beat command
        push_cmd(4'd0, 4'd15);
        repeat (6) step();
        chk("mr_beat6_idx", out_idx, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_onehot", out_onehot, 16'h0000);
        chk("mr_in_ready", in_ready, 1);
        n_pre = beats.size();
        chk("mr_pre_count", n_pre, 5);
        for (int i = 0; i < n_pre; i++)
            chk($sformatf("mr_pre_idx%0d", i), beats[i].idx, i);
        repeat (5) step();
        chk("mr_no_beats", beats.size(), n_pre);
        chk("mr_still_idle", out_valid, 0);
        beats.delete();
        push_cmd(4'd8, 4'd0);
        drain();
        exp_beat(4'd8, 16'h0100, 1'b1);
        check_beats("after_rst", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
